// File: rtl/fetch_unit_pkg.sv
// Shared widths, opcode field, halt opcode and FSM state encoding for the fetch stage.
package fetch_unit_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam logic [3:0]        HALT_OPCODE = 4'hF;
  localparam logic [ADDR_W-1:0] RESET_PC    = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } state_t;

  function automatic logic is_halt(input logic [OPC_HI-OPC_LO:0] opc);
    return opc == HALT_OPCODE;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory address/data, decode handshake, redirect and status.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] pc_out;
  logic [DATA_W-1:0] imem_data;
  logic [DATA_W-1:0] ir_out;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halted;
  logic [15:0]       fetch_count;

  modport master (
    input  start, imem_data, ir_ready, redirect, redirect_pc,
    output pc_out, ir_out, ir_pc, ir_valid, halted, fetch_count
  );

  modport slave (
    output start, imem_data, ir_ready, redirect, redirect_pc,
    input  pc_out, ir_out, ir_pc, ir_valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// PC and fetch control in front of a 1-cycle synchronous instruction memory.
// Stalls by re-presenting pc_q to the memory, so no skid buffer is required.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master fb
);

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       count_q;
  logic              ir_valid;
  logic              accept;
  logic              halt_op;
  logic [ADDR_W-1:0] pc_inc;

  assign halt_op  = is_halt(fb.imem_data[OPC_HI:OPC_LO]);
  assign ir_valid = (state == RUN) && !fb.redirect;
  assign accept   = ir_valid && fb.ir_ready;
  assign pc_inc   = pc_q + 1'b1;

  // Redirect in IDLE only reloads pc_q; the memory picks it up in FILL.
  always_comb begin
    fb.pc_out = pc_q;
    if (fb.redirect && state != IDLE)
      fb.pc_out = fb.redirect_pc;
    else if (accept && !halt_op)
      fb.pc_out = pc_inc;
  end

  assign fb.ir_valid    = ir_valid;
  assign fb.ir_out      = ir_valid ? fb.imem_data : '0;
  assign fb.ir_pc       = pc_q;
  assign fb.halted      = (state == HALTED);
  assign fb.fetch_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else if (fb.redirect) begin
      pc_q  <= fb.redirect_pc;
      state <= (state == IDLE) ? IDLE : FILL;
    end else begin
      case (state)
        IDLE:   if (fb.start) state <= FILL;
        FILL:   state <= RUN;
        RUN: begin
          if (accept) begin
            if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
            if (halt_op) state <= HALTED;
            else         pc_q  <= pc_inc;
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, halt, backpressure, redirects, wrap and async reset.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [DATA_W-1:0] mem [64];

  always #5 clk = ~clk;

  fetch_unit_if fif();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fb    (fif.master)
  );

  always @(posedge clk) fif.imem_data <= mem[fif.pc_out];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_chk(input string tag, input logic v, input logic [5:0] pc,
                         input logic [15:0] ir, input logic [5:0] pco);
    check({tag, ".valid"}, 32'(fif.ir_valid), 32'(v));
    check({tag, ".ir_pc"}, 32'(fif.ir_pc), 32'(pc));
    check({tag, ".ir_out"}, 32'(fif.ir_out), 32'(ir));
    check({tag, ".pc_out"}, 32'(fif.pc_out), 32'(pco));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'hF000;
    mem[5] = 16'h5555; mem[63] = 16'h6363;
    fif.start = 0; fif.ir_ready = 0; fif.redirect = 0; fif.redirect_pc = '0;
    fif.imem_data = '0;

    repeat (2) step();
    check("rst.valid", 32'(fif.ir_valid), 0);
    check("rst.pc_out", 32'(fif.pc_out), 0);
    check("rst.ir_pc", 32'(fif.ir_pc), 0);
    check("rst.ir_out", 32'(fif.ir_out), 0);
    check("rst.halted", 32'(fif.halted), 0);
    check("rst.count", 32'(fif.fetch_count), 0);
    rst_n = 1;
    step();

    // start and stream
    fif.start = 1; fif.ir_ready = 1; #1;
    check("idle.valid", 32'(fif.ir_valid), 0);
    step();
    fif.start = 0; #1;
    check("fill.valid", 32'(fif.ir_valid), 0);
    check("fill.pc_out", 32'(fif.pc_out), 0);
    step();
    run_chk("s0", 1, 0, 16'h1234, 1); step();
    run_chk("s1", 1, 1, 16'h2345, 2); step();
    run_chk("s2", 1, 2, 16'hF000, 2); step();

    // halted
    check("h.halted", 32'(fif.halted), 1);
    check("h.valid", 32'(fif.ir_valid), 0);
    check("h.pc_out", 32'(fif.pc_out), 2);
    check("h.count", 32'(fif.fetch_count), 3);
    check("h.ir_out", 32'(fif.ir_out), 0);
    fif.start = 1; step();
    fif.start = 0; step();
    check("h2.halted", 32'(fif.halted), 1);
    check("h2.valid", 32'(fif.ir_valid), 0);
    check("h2.count", 32'(fif.fetch_count), 3);

    // redirect from HALTED to 0, then backpressure at pc 1
    fif.redirect = 1; fif.redirect_pc = 6'd0; fif.ir_ready = 0; #1;
    check("rd0.pc_out", 32'(fif.pc_out), 0);
    check("rd0.valid", 32'(fif.ir_valid), 0);
    step();
    fif.redirect = 0; #1;
    check("rd0f.valid", 32'(fif.ir_valid), 0);
    check("rd0f.halted", 32'(fif.halted), 0);
    step();
    fif.ir_ready = 1; #1;
    run_chk("b0", 1, 0, 16'h1234, 1); step();
    fif.ir_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      run_chk("stall", 1, 1, 16'h2345, 1);
      check("stall.count", 32'(fif.fetch_count), 4);
      step();
    end
    fif.ir_ready = 1; #1;
    run_chk("b1", 1, 1, 16'h2345, 2); step();
    check("b1.count", 32'(fif.fetch_count), 5);
    run_chk("b2", 1, 2, 16'hF000, 2); step();
    check("b2.halted", 32'(fif.halted), 1);
    check("b2.count", 32'(fif.fetch_count), 6);

    // redirect from HALTED to 63, wrap to 0
    fif.redirect = 1; fif.redirect_pc = 6'd63; #1;
    check("rd63.pc_out", 32'(fif.pc_out), 63);
    step();
    fif.redirect = 0; #1;
    check("rd63f.valid", 32'(fif.ir_valid), 0);
    check("rd63f.halted", 32'(fif.halted), 0);
    step();
    run_chk("w63", 1, 63, 16'h6363, 0); step();
    run_chk("w0", 1, 0, 16'h1234, 1);
    check("w0.halted", 32'(fif.halted), 0);
    check("w0.count", 32'(fif.fetch_count), 7);

    // redirect in RUN to 5 with ir_ready high
    fif.redirect = 1; fif.redirect_pc = 6'd5; #1;
    check("rd5.valid", 32'(fif.ir_valid), 0);
    check("rd5.pc_out", 32'(fif.pc_out), 5);
    check("rd5.ir_out", 32'(fif.ir_out), 0);
    step();
    fif.redirect = 0; #1;
    check("rd5f.valid", 32'(fif.ir_valid), 0);
    check("rd5f.count", 32'(fif.fetch_count), 7);
    step();
    run_chk("r5", 1, 5, 16'h5555, 6);

    // async reset between edges
    #2;
    rst_n = 0; #1;
    check("arst.valid", 32'(fif.ir_valid), 0);
    check("arst.pc_out", 32'(fif.pc_out), 0);
    check("arst.count", 32'(fif.fetch_count), 0);
    check("arst.ir_pc", 32'(fif.ir_pc), 0);
    step();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post.valid", 32'(fif.ir_valid), 0);
      check("post.pc_out", 32'(fif.pc_out), 0);
    end
    fif.start = 1; step();
    fif.start = 0; step();
    run_chk("restart", 1, 0, 16'h1234, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
